eth_rx_frame_fifo: RTL and testbench

// Receive-side frame buffer between the Triple-Speed MAC RX user interface (rx_mac_*) and the

---
 rtl/eth_rx_frame_fifo.sv | 181 ++++++++++++++++++
 tb/tb_eth_rx_frame_fifo.sv | 287 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/eth_rx_frame_fifo.sv
// Receive frame buffer between the MAC RX byte stream and a valid/ready consumer.
// Frames are written speculatively and become visible only after a clean final byte.
module eth_rx_frame_fifo #(
    parameter int ADDR_W = 11,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              rx_mac_valid,
    input  logic [7:0]        rx_mac_data,
    input  logic              rx_mac_last,
    input  logic              rx_mac_error,
    output logic              out_valid,
    output logic [7:0]        out_data,
    output logic              out_last,
    input  logic              out_ready,
    output logic [ADDR_W:0]   frames_avail,
    output logic [CNT_W-1:0]  drop_err_cnt,
    output logic [CNT_W-1:0]  drop_ovf_cnt
);
    localparam int DEPTH = 1 << ADDR_W;
    localparam logic [ADDR_W:0]  PTR_ONE  = {{ADDR_W{1'b0}}, 1'b1};
    localparam logic [ADDR_W:0]  PTR_FULL = {1'b1, {ADDR_W{1'b0}}};
    localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};

    typedef enum logic [1:0] {IDLE, RECV, DISCARD} state_t;

    logic [8:0]      mem [DEPTH];
    logic [8:0]      rdata_q;

    state_t          state_q, state_d;
    logic [ADDR_W:0] wr_commit_q, wr_commit_d;
    logic [ADDR_W:0] wr_spec_q, wr_spec_d;
    logic [ADDR_W:0] rd_q, rd_d;
    logic [ADDR_W:0] frames_q, frames_d;
    logic            mem_valid_q, mem_valid_d;
    logic            out_valid_q, out_valid_d;
    logic [7:0]      out_data_q, out_data_d;
    logic            out_last_q, out_last_d;

    logic            full;
    logic            wr_en;
    logic            commit;
    logic [1:0]      drop_inc;
    logic            pop;
    logic            out_load;
    logic            rd_en;

    assign full = (wr_spec_q - rd_q) == PTR_FULL;

    // Write side: speculative pointer advances per byte, commit pointer only on a clean last.
    always_comb begin
        state_d     = state_q;
        wr_spec_d   = wr_spec_q;
        wr_commit_d = wr_commit_q;
        wr_en       = 1'b0;
        commit      = 1'b0;
        drop_inc    = 2'b00;
        if (rx_mac_valid) begin
            case (state_q)
                IDLE, RECV: begin
                    if (full) begin
                        wr_spec_d = wr_commit_q;
                        if (rx_mac_last) begin
                            drop_inc[1] = 1'b1;
                            state_d     = IDLE;
                        end else begin
                            state_d = DISCARD;
                        end
                    end else begin
                        wr_en = 1'b1;
                        if (rx_mac_last) begin
                            state_d = IDLE;
                            if (rx_mac_error) begin
                                wr_spec_d   = wr_commit_q;
                                drop_inc[0] = 1'b1;
                            end else begin
                                wr_spec_d   = wr_spec_q + PTR_ONE;
                                wr_commit_d = wr_spec_q + PTR_ONE;
                                commit      = 1'b1;
                            end
                        end else begin
                            wr_spec_d = wr_spec_q + PTR_ONE;
                            state_d   = RECV;
                        end
                    end
                end
                DISCARD: begin
                    if (rx_mac_last) begin
                        drop_inc[1] = 1'b1;
                        state_d     = IDLE;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    // Read side: RAM output register feeds a show-ahead output register, one byte per cycle.
    always_comb begin
        pop         = out_valid_q && out_ready;
        out_load    = !out_valid_q || pop;
        rd_en       = (rd_q != wr_commit_q) && (!mem_valid_q || out_load);
        rd_d        = rd_en ? rd_q + PTR_ONE : rd_q;
        mem_valid_d = rd_en || (mem_valid_q && !out_load);
        out_valid_d = out_load ? mem_valid_q : out_valid_q;
        out_data_d  = out_data_q;
        out_last_d  = out_last_q;
        if (out_load && mem_valid_q) begin
            out_data_d = rdata_q[7:0];
            out_last_d = rdata_q[8];
        end
        frames_d = frames_q;
        if (commit && !(pop && out_last_q)) begin
            frames_d = frames_q + PTR_ONE;
        end else if (!commit && pop && out_last_q) begin
            frames_d = frames_q - PTR_ONE;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_spec_q[ADDR_W-1:0]] <= {rx_mac_last, rx_mac_data};
        end
        if (rd_en) begin
            rdata_q <= mem[rd_q[ADDR_W-1:0]];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            wr_commit_q <= '0;
            wr_spec_q   <= '0;
            rd_q        <= '0;
            frames_q    <= '0;
            mem_valid_q <= 1'b0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_last_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            wr_commit_q <= wr_commit_d;
            wr_spec_q   <= wr_spec_d;
            rd_q        <= rd_d;
            frames_q    <= frames_d;
            mem_valid_q <= mem_valid_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_last_q  <= out_last_d;
        end
    end

    // Index 0 counts errored frames, index 1 overflowed frames; both stick at all-ones.
    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_cnt
            logic [CNT_W-1:0] cnt_q, cnt_d;
            always_comb begin
                cnt_d = cnt_q;
                if (drop_inc[gi] && (cnt_q != {CNT_W{1'b1}})) begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    cnt_q <= '0;
                end else begin
                    cnt_q <= cnt_d;
                end
            end
        end
    endgenerate

    assign out_valid    = out_valid_q;
    assign out_data     = out_data_q;
    assign out_last     = out_last_q;
    assign frames_avail = frames_q;
    assign drop_err_cnt = g_cnt[0].cnt_q;
    assign drop_ovf_cnt = g_cnt[1].cnt_q;
endmodule

// File: tb/tb_eth_rx_frame_fifo.sv
// Directed bench for eth_rx_frame_fifo: a frame table plus hand-written stall, coincidence and reset cases.
module tb_eth_rx_frame_fifo;
    localparam int ADDR_W = 6;
    localparam int CNT_W  = 4;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              rx_mac_valid = 1'b0;
    logic [7:0]        rx_mac_data = 8'h00;
    logic              rx_mac_last = 1'b0;
    logic              rx_mac_error = 1'b0;
    logic              out_valid;
    logic [7:0]        out_data;
    logic              out_last;
    logic              out_ready = 1'b1;
    logic [ADDR_W:0]   frames_avail;
    logic [CNT_W-1:0]  drop_err_cnt;
    logic [CNT_W-1:0]  drop_ovf_cnt;

    eth_rx_frame_fifo #(.ADDR_W(ADDR_W), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst),
        .rx_mac_valid(rx_mac_valid), .rx_mac_data(rx_mac_data),
        .rx_mac_last(rx_mac_last), .rx_mac_error(rx_mac_error),
        .out_valid(out_valid), .out_data(out_data), .out_last(out_last),
        .out_ready(out_ready), .frames_avail(frames_avail),
        .drop_err_cnt(drop_err_cnt), .drop_ovf_cnt(drop_ovf_cnt)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    logic [8:0] got_q[$];
    logic [8:0] exp_q[$];
    logic       stall_prev = 1'b0;
    logic [8:0] held = 9'h000;

    typedef struct {
        int         len;
        bit         err;
        logic [7:0] base;
        bit         deliver;
        int         exp_err;
        int         exp_ovf;
    } rec_t;
    rec_t tbl[9];

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        rx_mac_valid = 1'b0;
        rx_mac_last  = 1'b0;
        rx_mac_error = 1'b0;
    endtask

    task automatic send_frame(input int len, input bit err, input logic [7:0] base);
        for (int i = 0; i < len; i++) begin
            rx_mac_valid = 1'b1;
            rx_mac_data  = base + 8'(i);
            rx_mac_last  = (i == len - 1);
            rx_mac_error = err && (i == len - 1);
            step();
        end
    endtask

    task automatic push_exp(input int len, input logic [7:0] base);
        for (int i = 0; i < len; i++) begin
            exp_q.push_back({(i == len - 1), base + 8'(i)});
        end
    endtask

    task automatic drain();
        int n = 0;
        while ((frames_avail != 0 || out_valid) && n < 400) begin
            step();
            n++;
        end
        if (n >= 400) begin
            total++;
            bad++;
            $display("FAIL drain_timeout: got frames_avail=%0d out_valid=%0b expected empty", frames_avail, out_valid);
        end
    endtask

    task automatic compare_stream(input string name);
        int n;
        check({name, " count"}, 32'(got_q.size()), 32'(exp_q.size()));
        n = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
        for (int i = 0; i < n; i++) begin
            check($sformatf("%s byte%0d", name, i), 32'(got_q[i]), 32'(exp_q[i]));
        end
        got_q.delete();
        exp_q.delete();
    endtask

    task automatic do_reset();
        idle();
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
        step();
    endtask

    // Output monitor: collects handshakes and checks the output holds while stalled.
    always @(negedge clk) begin
        if (rst) begin
            stall_prev = 1'b0;
        end else begin
            if (stall_prev) begin
                check("stall_hold", 32'({out_valid, out_last, out_data}), 32'({1'b1, held}));
            end
            if (out_valid && out_ready) begin
                got_q.push_back({out_last, out_data});
            end
            stall_prev = out_valid && !out_ready;
            held       = {out_last, out_data};
        end
    end

    initial begin
        int fa_min;
        int fa_max;

        tbl[0] = '{64, 1'b0, 8'h00, 1'b1, 0, 0};
        tbl[1] = '{60, 1'b1, 8'h40, 1'b0, 1, 0};
        tbl[2] = '{10, 1'b0, 8'h80, 1'b1, 1, 0};
        tbl[3] = '{ 1, 1'b0, 8'hA5, 1'b1, 1, 0};
        tbl[4] = '{ 1, 1'b1, 8'h5A, 1'b0, 2, 0};
        tbl[5] = '{17, 1'b0, 8'h11, 1'b1, 2, 0};
        tbl[6] = '{65, 1'b0, 8'h20, 1'b0, 2, 1};
        tbl[7] = '{70, 1'b1, 8'h90, 1'b0, 2, 2};
        tbl[8] = '{ 5, 1'b0, 8'h33, 1'b1, 2, 2};

        do_reset();
        check("reset out_valid", 32'(out_valid), 0);
        check("reset out_data", 32'(out_data), 0);
        check("reset out_last", 32'(out_last), 0);
        check("reset frames_avail", 32'(frames_avail), 0);
        check("reset drop_err_cnt", 32'(drop_err_cnt), 0);
        check("reset drop_ovf_cnt", 32'(drop_ovf_cnt), 0);

        out_ready = 1'b1;
        for (int r = 0; r < 9; r++) begin
            send_frame(tbl[r].len, tbl[r].err, tbl[r].base);
            idle();
            if (tbl[r].deliver) push_exp(tbl[r].len, tbl[r].base);
            check($sformatf("rec%0d frames_after_last", r), 32'(frames_avail), 32'(tbl[r].deliver));
            drain();
            check($sformatf("rec%0d drop_err_cnt", r), 32'(drop_err_cnt), 32'(tbl[r].exp_err));
            check($sformatf("rec%0d drop_ovf_cnt", r), 32'(drop_ovf_cnt), 32'(tbl[r].exp_ovf));
            check($sformatf("rec%0d frames_drained", r), 32'(frames_avail), 0);
            compare_stream($sformatf("rec%0d", r));
            $display("rec %0d: len=%0d err=%0b -> err_cnt=%0d ovf_cnt=%0d", r, tbl[r].len, tbl[r].err, drop_err_cnt, drop_ovf_cnt);
        end

        // Overflow while the consumer is stalled: second frame must be dropped whole.
        do_reset();
        out_ready = 1'b0;
        send_frame(40, 1'b0, 8'h00);
        send_frame(40, 1'b0, 8'h60);
        idle();
        step();
        step();
        check("ovf drop_ovf_cnt", 32'(drop_ovf_cnt), 1);
        check("ovf frames_avail", 32'(frames_avail), 1);
        check("ovf show_ahead valid", 32'(out_valid), 1);
        check("ovf show_ahead data", 32'(out_data), 0);
        push_exp(40, 8'h00);
        out_ready = 1'b1;
        drain();
        compare_stream("ovf");
        check("ovf drop_err_cnt", 32'(drop_err_cnt), 0);
        $display("overflow case: ovf_cnt=%0d frames_avail=%0d", drop_ovf_cnt, frames_avail);

        // Three single-byte frames while ready toggles every cycle.
        do_reset();
        fork
            begin
                for (int k = 0; k < 20; k++) begin
                    out_ready = ~out_ready;
                    step();
                end
            end
            begin
                send_frame(1, 1'b0, 8'hE1);
                send_frame(1, 1'b0, 8'hE2);
                send_frame(1, 1'b0, 8'hE3);
                idle();
            end
        join
        out_ready = 1'b1;
        push_exp(1, 8'hE1);
        push_exp(1, 8'hE2);
        push_exp(1, 8'hE3);
        drain();
        compare_stream("single_bytes");
        $display("single-byte case: frames_avail=%0d", frames_avail);

        // Frame B commits on the same edge as the out_last handshake of frame A.
        do_reset();
        out_ready = 1'b1;
        fa_min = 99;
        fa_max = -1;
        send_frame(4, 1'b0, 8'hC0);
        fork
            begin
                send_frame(6, 1'b0, 8'hD0);
                idle();
            end
            begin
                for (int k = 0; k < 14; k++) begin
                    if (int'(frames_avail) < fa_min) fa_min = int'(frames_avail);
                    if (int'(frames_avail) > fa_max) fa_max = int'(frames_avail);
                    step();
                end
            end
        join
        check("coincide frames_min", 32'(fa_min), 1);
        check("coincide frames_max", 32'(fa_max), 1);
        push_exp(4, 8'hC0);
        push_exp(6, 8'hD0);
        drain();
        compare_stream("coincide");
        $display("coincide case: frames_avail min=%0d max=%0d", fa_min, fa_max);

        // Reset in the middle of a frame with two frames already committed.
        do_reset();
        out_ready = 1'b0;
        send_frame(3, 1'b0, 8'h01);
        send_frame(3, 1'b0, 8'h11);
        rx_mac_valid = 1'b1; rx_mac_data = 8'h21; rx_mac_last = 1'b0;
        step();
        step();
        check("midrst frames_before", 32'(frames_avail), 2);
        rst = 1'b1;
        idle();
        step();
        check("midrst out_valid", 32'(out_valid), 0);
        check("midrst frames_avail", 32'(frames_avail), 0);
        rst = 1'b0;
        step();
        got_q.delete();
        out_ready = 1'b1;
        send_frame(8, 1'b0, 8'h70);
        idle();
        push_exp(8, 8'h70);
        drain();
        compare_stream("after_rst");
        check("after_rst drop_err_cnt", 32'(drop_err_cnt), 0);
        $display("mid-frame reset case: frames_avail=%0d", frames_avail);

        // Saturation of the 4-bit error counter.
        for (int k = 0; k < 15; k++) send_frame(1, 1'b1, 8'(k));
        idle();
        step();
        check("sat err_cnt_15", 32'(drop_err_cnt), 15);
        send_frame(1, 1'b1, 8'hFF);
        idle();
        step();
        check("sat err_cnt_hold", 32'(drop_err_cnt), 15);
        check("sat ovf_cnt", 32'(drop_ovf_cnt), 0);
        check("sat frames_avail", 32'(frames_avail), 0);
        $display("saturation case: err_cnt=%0d", drop_err_cnt);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: got still running expected finished");
        $fatal(1, "timeout");
    end
endmodule
